vproc_pending_wr_tracker: RTL and testbench

- Clearing end of the vector-register pending-write protocol: holds per-instruction pending-write masks produced at dispatch and retires them bit-by-bit as execution units write back vregs.
- Sits between dispatcher and unit writeback buses.
- Provides the aggregate 32-bit pending vector and the RAW/WAW dispatch stall.
- Releases instruction IDs on completion, including instructions that stop early and never write some masked vregs.

---
 rtl/vproc_pending_wr_tracker_if.sv | 32 +++
 rtl/vproc_pending_wr_tracker.sv | 103 ++++++++++
 tb/tb_vproc_pending_wr_tracker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vproc_pending_wr_tracker_if.sv
// rtl/vproc_pending_wr_tracker_if.sv - dispatcher/writeback/done bundle for the pending-write tracker
interface vproc_pending_wr_tracker_if #(
   parameter int INSTR_ID_W = 3,
   parameter int WB_PORTS   = 2
);
   logic                           flush_i;
   logic                           alloc_valid_i;
   logic                           alloc_ready_o;
   logic [INSTR_ID_W-1:0]          alloc_id_i;
   logic [31:0]                    alloc_mask_i;
   logic [31:0]                    alloc_rs_mask_i;
   logic [WB_PORTS-1:0]            wb_valid_i;
   logic [WB_PORTS*INSTR_ID_W-1:0] wb_id_i;
   logic [WB_PORTS*5-1:0]          wb_vreg_i;
   logic                           done_valid_i;
   logic [INSTR_ID_W-1:0]          done_id_i;
   logic [31:0]                    pending_o;
   logic                           busy_o;
   logic                           err_o;

   modport master (
      output flush_i, alloc_valid_i, alloc_id_i, alloc_mask_i, alloc_rs_mask_i,
             wb_valid_i, wb_id_i, wb_vreg_i, done_valid_i, done_id_i,
      input  alloc_ready_o, pending_o, busy_o, err_o
   );

   modport slave (
      input  flush_i, alloc_valid_i, alloc_id_i, alloc_mask_i, alloc_rs_mask_i,
             wb_valid_i, wb_id_i, wb_vreg_i, done_valid_i, done_id_i,
      output alloc_ready_o, pending_o, busy_o, err_o
   );
endinterface

// File: rtl/vproc_pending_wr_tracker.sv
// rtl/vproc_pending_wr_tracker.sv - per-instruction vreg pending-write table with RAW/WAW dispatch stall
module vproc_pending_wr_tracker #(
   parameter int INSTR_ID_W = 3,
   parameter int WB_PORTS   = 2
) (
   input  logic                    clk_i,
   input  logic                    async_rst_ni,
   vproc_pending_wr_tracker_if.slave bus_if
);
   localparam int N = 2 ** INSTR_ID_W;

   logic [N-1:0]          r_valid;
   logic [31:0]           r_mask [N];
   logic                  r_err;

   logic [INSTR_ID_W-1:0] w_wb_id   [WB_PORTS];
   logic [4:0]            w_wb_vreg [WB_PORTS];
   logic [31:0]           w_clr     [N];
   logic [N-1:0]          w_done;
   logic                  w_err;
   logic [31:0]           w_pending;
   logic                  w_ready;
   logic                  w_accept;

   for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb_unpack
      assign w_wb_id[p]   = bus_if.wb_id_i[p*INSTR_ID_W +: INSTR_ID_W];
      assign w_wb_vreg[p] = bus_if.wb_vreg_i[p*5 +: 5];
   end

   // Invalid entries always hold a zero mask, so a plain OR is the aggregate.
   always_comb begin
      w_pending = '0;
      for (int e = 0; e < N; e++) begin
         w_pending = w_pending | r_mask[e];
      end
   end

   // Clears and errors are judged against cycle-start state, so two ports
   // hitting the same live bit both count as legal.
   always_comb begin
      w_err  = 1'b0;
      w_done = '0;
      for (int e = 0; e < N; e++) begin
         w_clr[e] = '0;
      end
      for (int p = 0; p < WB_PORTS; p++) begin
         if (bus_if.wb_valid_i[p]) begin
            if (!r_valid[w_wb_id[p]] || !r_mask[w_wb_id[p]][w_wb_vreg[p]]) begin
               w_err = 1'b1;
            end else begin
               w_clr[w_wb_id[p]][w_wb_vreg[p]] = 1'b1;
            end
         end
      end
      if (bus_if.done_valid_i) begin
         if (!r_valid[bus_if.done_id_i]) begin
            w_err = 1'b1;
         end else begin
            w_done[bus_if.done_id_i] = 1'b1;
         end
      end
   end

   assign w_ready  = async_rst_ni && !r_valid[bus_if.alloc_id_i] && !bus_if.flush_i &&
                     (((bus_if.alloc_mask_i | bus_if.alloc_rs_mask_i) & w_pending) == 32'd0);
   assign w_accept = bus_if.alloc_valid_i && w_ready;

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         r_valid <= '0;
         r_err   <= 1'b0;
         for (int e = 0; e < N; e++) begin
            r_mask[e] <= '0;
         end
      end else if (bus_if.flush_i) begin
         r_valid <= '0;
         for (int e = 0; e < N; e++) begin
            r_mask[e] <= '0;
         end
      end else begin
         r_err <= r_err | w_err;
         for (int e = 0; e < N; e++) begin
            if (w_done[e]) begin
               r_valid[e] <= 1'b0;
               r_mask[e]  <= '0;
            end else begin
               r_mask[e]  <= r_mask[e] & ~w_clr[e];
            end
         end
         // An accepted ID was invalid at cycle start, so it never collides with a clear or done.
         if (w_accept) begin
            r_valid[bus_if.alloc_id_i] <= 1'b1;
            r_mask[bus_if.alloc_id_i]  <= bus_if.alloc_mask_i;
         end
      end
   end

   assign bus_if.alloc_ready_o = w_ready;
   assign bus_if.pending_o     = w_pending;
   assign bus_if.busy_o        = |r_valid;
   assign bus_if.err_o         = r_err;

endmodule

// File: tb/tb_vproc_pending_wr_tracker.sv
// tb/tb_vproc_pending_wr_tracker.sv - directed and randomized checks of the pending-write tracker
module tb_vproc_pending_wr_tracker;
   localparam int IDW = 3;
   localparam int NP  = 2;
   localparam int N   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference: set of in-flight instructions, each with its outstanding vreg set.
   bit          m_live [N];
   logic [31:0] m_regs [N];
   bit          m_err;

   vproc_pending_wr_tracker_if #(.INSTR_ID_W(IDW), .WB_PORTS(NP)) bus ();

   vproc_pending_wr_tracker #(.INSTR_ID_W(IDW), .WB_PORTS(NP)) dut (
      .clk_i        (clk),
      .async_rst_ni (rst_n),
      .bus_if       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_pending();
      logic [31:0] acc = 32'd0;
      for (int i = 0; i < N; i++) if (m_live[i]) acc = acc | m_regs[i];
      return acc;
   endfunction

   function automatic bit m_any();
      for (int i = 0; i < N; i++) if (m_live[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_ready();
      return !m_live[bus.alloc_id_i] && !bus.flush_i &&
             (((bus.alloc_mask_i | bus.alloc_rs_mask_i) & m_pending()) == 32'd0);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin m_live[i] = 1'b0; m_regs[i] = 32'd0; end
      m_err = 1'b0;
   endtask

   // Applies one clock edge worth of spec rules to the reference.
   task automatic m_step(input bit rdy);
      logic [31:0] drop [N];
      bit          fin  [N];
      int          id, v;
      if (bus.flush_i) begin
         for (int i = 0; i < N; i++) begin m_live[i] = 1'b0; m_regs[i] = 32'd0; end
         return;
      end
      for (int i = 0; i < N; i++) begin drop[i] = 32'd0; fin[i] = 1'b0; end
      for (int p = 0; p < NP; p++) begin
         if (bus.wb_valid_i[p]) begin
            id = int'(bus.wb_id_i[p*IDW +: IDW]);
            v  = int'(bus.wb_vreg_i[p*5 +: 5]);
            if (!m_live[id] || !m_regs[id][v]) m_err = 1'b1;
            else drop[id][v] = 1'b1;
         end
      end
      if (bus.done_valid_i) begin
         if (!m_live[bus.done_id_i]) m_err = 1'b1;
         else fin[bus.done_id_i] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         m_regs[i] = m_regs[i] & ~drop[i];
         if (fin[i]) begin m_live[i] = 1'b0; m_regs[i] = 32'd0; end
      end
      if (bus.alloc_valid_i && rdy) begin
         m_live[bus.alloc_id_i] = 1'b1;
         m_regs[bus.alloc_id_i] = bus.alloc_mask_i;
      end
   endtask

   task automatic idle();
      bus.flush_i = 1'b0; bus.alloc_valid_i = 1'b0; bus.alloc_id_i = '0;
      bus.alloc_mask_i = '0; bus.alloc_rs_mask_i = '0; bus.wb_valid_i = '0;
      bus.wb_id_i = '0; bus.wb_vreg_i = '0; bus.done_valid_i = 1'b0; bus.done_id_i = '0;
   endtask

   // Inputs are already driven; check outputs mid-cycle, then advance the model at the edge.
   task automatic cycle(input int want_rdy = -1);
      bit rdy;
      @(negedge clk);
      rdy = m_ready();
      check("ready_model", {31'd0, bus.alloc_ready_o}, {31'd0, rdy});
      if (want_rdy >= 0) check("ready_plan", {31'd0, bus.alloc_ready_o}, want_rdy[31:0]);
      check("pending", bus.pending_o, m_pending());
      check("busy", {31'd0, bus.busy_o}, {31'd0, m_any()});
      check("err", {31'd0, bus.err_o}, {31'd0, m_err});
      @(posedge clk);
      m_step(rdy);
      #1;
   endtask

   task automatic alloc(input int id, input logic [31:0] mask, input logic [31:0] rs, input int want);
      idle();
      bus.alloc_valid_i = 1'b1; bus.alloc_id_i = id[IDW-1:0];
      bus.alloc_mask_i = mask; bus.alloc_rs_mask_i = rs;
      cycle(want);
      idle();
   endtask

   task automatic wb(input int p, input int id, input int vreg);
      bus.wb_valid_i[p] = 1'b1;
      bus.wb_id_i[p*IDW +: IDW] = id[IDW-1:0];
      bus.wb_vreg_i[p*5 +: 5] = vreg[4:0];
   endtask

   function automatic int pick_bit(input logic [31:0] m);
      int s = $urandom_range(0, 31);
      for (int k = 0; k < 32; k++) if (m[(s + k) % 32]) return (s + k) % 32;
      return s;
   endfunction

   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1;
      m_reset();
      check("rst_pending", bus.pending_o, 32'd0);
      check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("rst_err", {31'd0, bus.err_o}, 32'd0);
      check("rst_ready", {31'd0, bus.alloc_ready_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int id;
      idle();
      m_reset();
      #2;
      bus.alloc_valid_i = 1'b1;
      check("rst_pending0", bus.pending_o, 32'd0);
      check("rst_busy0", {31'd0, bus.busy_o}, 32'd0);
      check("rst_err0", {31'd0, bus.err_o}, 32'd0);
      check("rst_ready0", {31'd0, bus.alloc_ready_o}, 32'd0);
      idle();
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      alloc(2, 32'h0000_00F0, 32'd0, 1);
      check("t1_pending", bus.pending_o, 32'h0000_00F0);
      check("t1_busy", {31'd0, bus.busy_o}, 32'd1);

      alloc(3, 32'h0000_0100, 32'h0000_0010, 0);
      wb(0, 2, 4);
      cycle();
      idle();
      check("t2_pending", bus.pending_o, 32'h0000_00E0);
      bus.alloc_id_i = 3'd3; bus.alloc_mask_i = 32'h0000_0100; bus.alloc_rs_mask_i = 32'h0000_0010;
      cycle(1);
      idle();

      wb(0, 2, 5); wb(1, 2, 6);
      cycle();
      idle();
      check("t3_pending", bus.pending_o, 32'h0000_0080);
      check("t3_busy", {31'd0, bus.busy_o}, 32'd1);
      alloc(2, 32'h0000_0001, 32'd0, 0);
      bus.done_valid_i = 1'b1; bus.done_id_i = 3'd2;
      cycle();
      idle();
      check("t3_done_pending", bus.pending_o, 32'd0);
      check("t3_done_busy", {31'd0, bus.busy_o}, 32'd0);
      alloc(2, 32'h0000_0002, 32'd0, 1);
      bus.done_valid_i = 1'b1; bus.done_id_i = 3'd2;
      cycle();
      idle();

      wb(0, 5, 3);
      cycle();
      idle();
      check("t4_err", {31'd0, bus.err_o}, 32'd1);
      check("t4_pending", bus.pending_o, 32'd0);
      cycle(); cycle();
      check("t4_err_sticky", {31'd0, bus.err_o}, 32'd1);

      for (int i = 0; i < N; i++) alloc(i, 32'd1 << i, 32'd0, 1);
      check("t5_pending", bus.pending_o, 32'h0000_00FF);
      bus.done_valid_i = 1'b1; bus.done_id_i = 3'd0;
      cycle();
      idle();
      bus.flush_i = 1'b1; bus.alloc_valid_i = 1'b1; bus.alloc_id_i = 3'd0;
      bus.alloc_mask_i = 32'h0000_0100;
      cycle(0);
      idle();
      check("t5_flush_pending", bus.pending_o, 32'd0);
      check("t5_flush_busy", {31'd0, bus.busy_o}, 32'd0);
      check("t5_flush_err", {31'd0, bus.err_o}, 32'd1);

      alloc(0, 32'h0000_0F00, 32'd0, 1);
      check("t6_pending", bus.pending_o, 32'h0000_0F00);
      do_reset();

      for (int c = 0; c < 3000; c++) begin
         idle();
         if (c % 700 == 699) do_reset();
         if ($urandom_range(0, 99) < 2) begin
            bus.flush_i = 1'b1;
         end else begin
            for (int p = 0; p < NP; p++) begin
               if ($urandom_range(0, 99) < 45) begin
                  id = $urandom_range(0, N - 1);
                  if ($urandom_range(0, 99) < 97) wb(p, id, pick_bit(m_regs[id]));
                  else wb(p, id, $urandom_range(0, 31));
               end
            end
            if ($urandom_range(0, 99) < 15) begin
               bus.done_valid_i = 1'b1;
               bus.done_id_i = IDW'($urandom_range(0, N - 1));
            end
         end
         bus.alloc_valid_i = ($urandom_range(0, 99) < 60);
         bus.alloc_id_i = IDW'($urandom_range(0, N - 1));
         bus.alloc_mask_i = $urandom & $urandom & 32'h0000_FFFF;
         bus.alloc_rs_mask_i = $urandom & $urandom & $urandom & 32'h0000_FFFF;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
